// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: sequencer state encoding, default cycle
// constants and the relock counter width.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT_HOLD = 3'd4
    } rst_state_e;

    localparam int unsigned PLL_RST_CYCLES_DEF     = 32'd16;
    localparam int unsigned LOCK_STABLE_CYCLES_DEF = 32'd256;
    localparam int unsigned LOCK_TIMEOUT_DEF       = 32'd65535;
    localparam int unsigned REL_GAP_DEF            = 32'd16;
    localparam int unsigned LOSS_FILTER_DEF        = 32'd4;
    localparam int unsigned RELOCK_CNT_W           = 32'd8;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        max2 = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // metastability filter chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer on the always-running reference clock.
// Optional saturating relock counter enabled by PLL_RST_SEQ_RELOCK_CNT_EN.
module pll_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
    parameter int unsigned REL_GAP            = REL_GAP_DEF,
    parameter int unsigned LOSS_FILTER        = LOSS_FILTER_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    input  logic                    sw_rst_req,
    output logic                    pll_reset,
    output logic                    periph_rst_n,
    output logic                    cpu_rst_n,
    output logic                    locked_ok,
    output logic [RELOCK_CNT_W-1:0] relock_cnt
);

    localparam int unsigned MAX_PARAM = max2(max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                                  max2(LOCK_TIMEOUT, REL_GAP)), LOSS_FILTER);
    localparam int unsigned CNT_W = $clog2(MAX_PARAM) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rst_state_e       state_r;
    rst_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] stable_r;
    logic [CNT_W-1:0] loss_r;
    logic             lock_s;
    logic             lock_lost_s;
    logic             pll_reset_r;
    logic             periph_rst_n_r;
    logic             cpu_rst_n_r;
    logic             locked_ok_r;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // this cycle is the LOSS_FILTER-th consecutive low lock sample
    assign lock_lost_s = (!lock_s) && (loss_r == CNT_W'(LOSS_FILTER - 32'd1));

    // next-state selection; lock loss outranks soft reset requests
    always_comb begin
        state_s = state_r;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == CNT_W'(PLL_RST_CYCLES - 32'd1)) state_s = WAIT_LOCK;
                else                                         state_s = PLL_RST;
            end
            WAIT_LOCK: begin
                if (stable_r == CNT_W'(LOCK_STABLE_CYCLES))           state_s = RELEASE;
                else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 32'd1))       state_s = PLL_RST;
                else                                                  state_s = WAIT_LOCK;
            end
            RELEASE: begin
                if (lock_lost_s)                                 state_s = PLL_RST;
                else if (sw_rst_req)                             state_s = SOFT_HOLD;
                else if (cnt_r == CNT_W'(REL_GAP - 32'd1))       state_s = RUN;
                else                                             state_s = RELEASE;
            end
            RUN: begin
                if (lock_lost_s)     state_s = PLL_RST;
                else if (sw_rst_req) state_s = SOFT_HOLD;
                else                 state_s = RUN;
            end
            SOFT_HOLD: begin
                if (cnt_r == CNT_W'(PLL_RST_CYCLES - 32'd1)) state_s = lock_s ? RELEASE : WAIT_LOCK;
                else                                         state_s = SOFT_HOLD;
            end
            default: state_s = PLL_RST;
        endcase
    end

    // state register plus shared, stability and loss counters (cleared on any transition)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= PLL_RST;
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= {CNT_W{1'b0}};
            loss_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r    <= {CNT_W{1'b0}};
                stable_r <= {CNT_W{1'b0}};
                loss_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r    <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
                stable_r <= !lock_s ? {CNT_W{1'b0}} : ((stable_r == CNT_MAX) ? stable_r : stable_r + 1'b1);
                loss_r   <= lock_s ? {CNT_W{1'b0}} : ((loss_r == CNT_MAX) ? loss_r : loss_r + 1'b1);
            end
        end
    end

    // outputs registered from the next state so both resets assert together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset_r    <= 1'b1;
            periph_rst_n_r <= 1'b0;
            cpu_rst_n_r    <= 1'b0;
            locked_ok_r    <= 1'b0;
        end else begin
            pll_reset_r    <= (state_s == PLL_RST);
            periph_rst_n_r <= (state_s == RELEASE) || (state_s == RUN);
            cpu_rst_n_r    <= (state_s == RUN);
            locked_ok_r    <= (state_s == RUN);
        end
    end

    assign pll_reset    = pll_reset_r;
    assign periph_rst_n = periph_rst_n_r;
    assign cpu_rst_n    = cpu_rst_n_r;
    assign locked_ok    = locked_ok_r;

`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
    logic                    relock_evt_s;
    logic [RELOCK_CNT_W-1:0] relock_cnt_r;

    assign relock_evt_s = (state_s == PLL_RST) && ((state_r == RUN) || (state_r == WAIT_LOCK));

    // saturating relock event counter, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_cnt_r <= {RELOCK_CNT_W{1'b0}};
        end else if (relock_evt_s && (relock_cnt_r != {RELOCK_CNT_W{1'b1}})) begin
            relock_cnt_r <= relock_cnt_r + 1'b1;
        end else begin
            relock_cnt_r <= relock_cnt_r;
        end
    end

    assign relock_cnt = relock_cnt_r;
`else
    assign relock_cnt = {RELOCK_CNT_W{1'b0}};
`endif

endmodule
